// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: request/response bundle used by both requester ports and the controller side
interface sram_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic rd_en, wr_en, ready;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data, read_data;
  modport master (output rd_en, wr_en, address, write_data, input read_data, ready);
  modport slave (input rd_en, wr_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin sharing of one SRAM controller between the MEM port (a) and fetch port (b)
module sram_arbiter #(parameter int ADDR_W = 32, parameter int DATA_W = 32) (
  input logic clk,
  input logic rst,
  sram_arbiter_if.slave a,
  sram_arbiter_if.slave b,
  sram_arbiter_if.master mem
);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic owner, op_wr, last_grant, a_req, b_req, grant_b, en;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, a_rdata, b_rdata;
  assign a_req = a.rd_en | a.wr_en;
  assign b_req = b.rd_en | b.wr_en;
  assign grant_b = b_req & (~a_req | ~last_grant);
  always_comb begin
    state_nx = state;
    en = 1'b0;
    case (state)
      IDLE: state_nx = (a_req | b_req) ? ISSUE : IDLE;
      ISSUE: begin
        en = 1'b1;
        state_nx = mem.ready ? ISSUE : BUSY;
      end
      // drop the enable as soon as the controller is idle again so it never restarts
      BUSY: begin
        en = ~mem.ready;
        state_nx = mem.ready ? DONE : BUSY;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      op_wr <= 1'b0;
      last_grant <= 1'b1;
      addr_q <= '0;
      wdata_q <= '0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (a_req | b_req)) begin
        owner <= grant_b;
        last_grant <= grant_b;
        op_wr <= grant_b ? b.wr_en : a.wr_en;
        addr_q <= grant_b ? b.address : a.address;
        wdata_q <= grant_b ? b.write_data : a.write_data;
      end
      if (state == BUSY && mem.ready && !op_wr) begin
        if (owner) b_rdata <= mem.read_data;
        else a_rdata <= mem.read_data;
      end
    end
  end
  assign mem.rd_en = en & ~op_wr;
  assign mem.wr_en = en & op_wr;
  assign mem.address = addr_q;
  assign mem.write_data = wdata_q;
  assign a.read_data = a_rdata;
  assign b.read_data = b_rdata;
  assign a.ready = ~a_req | (state == DONE && !owner);
  assign b.ready = ~b_req | (state == DONE && owner);
endmodule
